// File: rtl/dual_nand4_bist_pkg.sv
// Shared types and helpers for the dual 4-input NAND self-test engine.
package dual_nand4_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Fibonacci taps q7, q5, q4, q3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned GRP_W  = 4;
  localparam int unsigned P1_LSB = 0;
  localparam int unsigned P2_LSB = 4;

  // Expected NAND outputs for a vector: [0]=p1y, [1]=p2y
  function automatic logic [1:0] nand_ref(input logic [7:0] v);
    return {~&v[P2_LSB +: GRP_W], ~&v[P1_LSB +: GRP_W]};
  endfunction

endpackage

// File: rtl/bist_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and advance enable.
module bist_lfsr8
  import dual_nand4_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/dual_nand4_bist.sv
// Self-test engine driving and checking the dual 4-input NAND block.
// DUAL_NAND4_BIST_EXHAUSTIVE_EN selects a 00..FF counter instead of the LFSR.
module dual_nand4_bist
  import dual_nand4_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [7:0]       dut_in,
  input  logic [1:0]       dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       first_fail,
  output logic             fail_valid
);

`ifdef DUAL_NAND4_BIST_EXHAUSTIVE_EN
  localparam int unsigned NV = 256;
`else
  localparam int unsigned NV = NUM_VECTORS;
`endif
  localparam logic [7:0]  LAST_IDX = 8'(NV - 1);
  localparam int unsigned SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam int unsigned SUM_W    = ERR_W + 1;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [7:0]         idx_q, idx_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [7:0]         ff_q, ff_d;
  logic               fv_q, fv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               src_load_c, src_adv_c;
  logic [7:0]         vec;
  logic [1:0]         exp_c, mism_c;
  logic [SUM_W-1:0]   err_sum_c;
  logic [ERR_W-1:0]   err_sat_c;

`ifdef DUAL_NAND4_BIST_EXHAUSTIVE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= 8'h00;
    end else if (src_load_c) begin
      vec <= 8'h00;
    end else if (src_adv_c) begin
      vec <= vec + 8'd1;
    end
  end
`else
  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  bist_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (src_load_c),
    .en    (src_adv_c),
    .seed  (SEED_EFF),
    .q     (vec)
  );
`endif

  // Unknown output bits never match, so they are scored as errors
  always_comb begin
    exp_c = nand_ref(vec);
    for (int i = 0; i < 2; i++) begin
      mism_c[i] = (dut_y[i] === exp_c[i]) ? 1'b0 : 1'b1;
    end
    err_sum_c = {1'b0, err_q} + SUM_W'(mism_c[0]) + SUM_W'(mism_c[1]);
    err_sat_c = err_sum_c[ERR_W] ? {ERR_W{1'b1}} : err_sum_c[ERR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      idx_q    <= 8'h00;
      err_q    <= '0;
      ff_q     <= 8'h00;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      fv_q     <= fv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    idx_d      = idx_q;
    err_d      = err_q;
    ff_d       = ff_q;
    fv_d       = fv_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    src_load_c = 1'b0;
    src_adv_c  = 1'b0;
    case (state_q)
      IDLE, FINISH: begin
        if (start) begin
          state_d    = APPLY;
          src_load_c = 1'b1;
          settle_d   = '0;
          idx_d      = 8'h00;
          err_d      = '0;
          ff_d       = 8'h00;
          fv_d       = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      APPLY: begin
        if (settle_q == SET_LAST) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      CHECK: begin
        err_d = err_sat_c;
        if ((mism_c != 2'b00) && !fv_q) begin
          ff_d = vec;
          fv_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_sat_c == '0);
        end else begin
          state_d   = APPLY;
          idx_d     = idx_q + 8'd1;
          settle_d  = '0;
          src_adv_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_in     = vec;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_dual_nand4_bist.sv
// Scoreboard bench for dual_nand4_bist with a faultable NAND model on dut_y.
module tb_dual_nand4_bist;

`ifdef DUAL_NAND4_BIST_EXHAUSTIVE_EN
  localparam int unsigned NV = 256;
  localparam int unsigned EW = 8;
`else
  localparam int unsigned NV = 16;
  localparam int unsigned EW = 5;
`endif
  localparam int unsigned SC   = 1;
  localparam logic [7:0]  SEED = 8'hA5;
  localparam int unsigned RUN_LEN = NV * (SC + 1);

  typedef struct {
    int         err;
    logic [7:0] ff;
    bit         fv;
    bit         ps;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    dut_in;
  logic [1:0]    dut_y;
  logic          busy, done, pass, fail_valid;
  logic [EW-1:0] err_count;
  logic [7:0]    first_fail;

  int         n_checks = 0;
  int         n_fail = 0;
  int         fault_mode = 0;
  logic [3:0] r1 = 4'h0;
  logic [3:0] r2 = 4'h0;
  logic [7:0] exp_vec [256];
  exp_t       sb_q[$];

  dual_nand4_bist #(
    .NUM_VECTORS   (NV),
    .SETTLE_CYCLES (SC),
    .LFSR_SEED     (SEED),
    .ERR_W         (EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dut_in     (dut_in),
    .dut_y      (dut_y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .fail_valid (fail_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [1:0] good_y(input logic [7:0] v);
    return {(v[7:4] == 4'hF) ? 1'b0 : 1'b1, (v[3:0] == 4'hF) ? 1'b0 : 1'b1};
  endfunction

  // Behaviour of the NAND block under each injected fault
  function automatic logic [1:0] model_y(input logic [7:0] v, input int mode,
                                         input logic [3:0] a, input logic [3:0] b);
    logic [1:0] y;
    y = good_y(v);
    case (mode)
      1: y[0] = 1'b1;
      2: y[1] = 1'b0;
      3: y = ~y;
      4: begin
        if (v[3:0] == a) y[0] = ~y[0];
        if (v[7:4] == b) y[1] = ~y[1];
      end
      default: ;
    endcase
    return y;
  endfunction

  assign dut_y = model_y(dut_in, fault_mode, r1, r2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Build the vector list and the expected result of a run in a given fault mode
  task automatic prepare(input int mode, output exp_t e);
    logic [7:0] v;
    logic [1:0] m;
    fault_mode = mode;
    r1 = 4'($urandom_range(0, 15));
    r2 = 4'($urandom_range(0, 15));
    v = SEED;
    e.err = 0; e.ff = 8'h00; e.fv = 1'b0;
    for (int i = 0; i < int'(NV); i++) begin
`ifdef DUAL_NAND4_BIST_EXHAUSTIVE_EN
      v = 8'(i);
`endif
      exp_vec[i] = v;
      m = model_y(v, mode, r1, r2) ^ good_y(v);
      e.err += $countones(m);
      if (m != 2'b00 && !e.fv) begin
        e.fv = 1'b1;
        e.ff = v;
      end
      v = lfsr_next(v);
    end
    if (e.err > (1 << EW) - 1) e.err = (1 << EW) - 1;
    e.ps = (e.err == 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // One full run; optionally fires extra starts that must be ignored
  task automatic run(input int mode, input bit spam);
    exp_t e;
    int k;
    prepare(mode, e);
    sb_q.push_back(e);
    pulse_start();
    k = 0;
    while (!(done && !busy) && k < int'(RUN_LEN) + 20) begin
      @(posedge clk); #1;
      start = spam && (k == 3 || k == 10 || k == int'(RUN_LEN) - 4);
      k++;
    end
    start = 1'b0;
    n_checks++;
    if (k >= int'(RUN_LEN) + 20) begin
      n_fail++;
      $display("FAIL run_timeout: done not seen after %0d cycles", k);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle vector check while busy, result check on done rising
  int cyc = 0;
  bit done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      cyc = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) begin
        if (cyc < int'(RUN_LEN)) check("dut_in_vector", 32'(dut_in), 32'(exp_vec[cyc / (SC + 1)]));
        cyc++;
      end
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("run_length", 32'(cyc), 32'(RUN_LEN));
          check("busy_low_at_done", 32'(busy), 32'd0);
          check("err_count", 32'(err_count), 32'(e.err));
          check("fail_valid", 32'(fail_valid), 32'(e.fv));
          check("first_fail", 32'(first_fail), 32'(e.ff));
          check("pass", 32'(pass), 32'(e.ps));
        end
        cyc = 0;
      end
      done_prev = done;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_dut_in"}, 32'(dut_in), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_first_fail"}, 32'(first_fail), 32'd0);
    check({tag, "_fail_valid"}, 32'(fail_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run(0, 1'b0);
    run(1, 1'b0);
    run(2, 1'b0);
    run(3, 1'b0);
    run(0, 1'b1);
    run(4, 1'b1);

    // Abort part-way through the 5th vector
    prepare(0, e);
    pulse_start();
    repeat (4 * (SC + 1)) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("abort");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_abort");

    run(0, 1'b0);
    for (int i = 0; i < 4; i++) run(int'($urandom_range(0, 4)), 1'(i % 2));

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
